// File: rtl/tick_divider.sv
// Multi-channel runtime-programmable tick / 50%-duty clock divider with shadowed divisors.
// Optional cascade (channel k advances on tick[k-1]) enabled by defining TICK_DIVIDER_CASCADE_EN.
module tick_divider #(
   parameter int CH       = 3,
   parameter int W        = 32,
   parameter int DIV_INIT = 50000000,
   localparam int SELW    = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            div_wr,
   input  logic [SELW-1:0] div_sel,
   input  logic [W-1:0]    div_val,
   output logic [CH-1:0]   tick,
   output logic [CH-1:0]   clk_out,
   output logic [CH-1:0]   pend
);

   for (genvar k = 0; k < CH; k++) begin : g_ch
      logic [W-1:0] cnt_q, cnt_d;
      logic [W-1:0] act_q, act_d;
      logic [W-1:0] shd_q, shd_d;
      logic         pend_q, pend_d;
      logic         tick_q, tick_d;
      logic         clk_q, clk_d;
      logic         adv;
      logic         wr_hit;
      logic         term;

      if (k == 0) begin : g_adv_first
         assign adv = en;
      end else begin : g_adv_rest
`ifdef TICK_DIVIDER_CASCADE_EN
         assign adv = en & tick[k-1];
`else
         assign adv = en;
`endif
      end

      // Selects >= CH never match any channel, so out-of-range writes drop out here.
      assign wr_hit = div_wr && (div_sel == SELW'(k));
      assign term   = (act_q != '0) && (cnt_q == act_q - W'(1));

      always_comb begin
         cnt_d  = cnt_q;
         act_d  = act_q;
         shd_d  = shd_q;
         pend_d = pend_q;
         tick_d = 1'b0;
         clk_d  = clk_q;
         if (act_q == '0) begin
            // Disabled channel: nothing to protect, so a pending divisor applies at once.
            cnt_d = '0;
            if (pend_q) begin
               act_d  = shd_q;
               pend_d = 1'b0;
            end
         end else if (adv) begin
            if (term) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               clk_d  = ~clk_q;
               if (pend_q) begin
                  act_d  = shd_q;
                  pend_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + W'(1);
            end
         end
         // Capture after the apply so a same-cycle write stays pending for the next period.
         if (wr_hit) begin
            shd_d  = div_val;
            pend_d = 1'b1;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q  <= '0;
            act_q  <= W'(DIV_INIT);
            shd_q  <= W'(DIV_INIT);
            pend_q <= 1'b0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
            clk_q  <= clk_d;
         end
      end

      assign tick[k]    = tick_q;
      assign clk_out[k] = clk_q;
      assign pend[k]    = pend_q;
   end

endmodule

// File: tb/tb_tick_divider.sv
// Scoreboard bench for tick_divider: directed scenarios plus random writes/enables,
// checked against a count-down reference model; honours TICK_DIVIDER_CASCADE_EN.
module tb_tick_divider;
  localparam int CH       = 3;
  localparam int W        = 8;
  localparam int DIV_INIT = 4;
  localparam int SELW     = 2;
  localparam int OW       = 3 * CH;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            div_wr = 1'b0;
  logic [SELW-1:0] div_sel = '0;
  logic [W-1:0]    div_val = '0;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   pend;

  int errors = 0;
  int checks = 0;
  logic [OW-1:0] exp_q[$];

  // reference model: cycles left until the next tick, per channel
  int m_left[CH];
  int m_act[CH];
  int m_shd[CH];
  bit m_pend[CH];
  bit m_tick[CH];
  bit m_clk[CH];

  tick_divider #(.CH(CH), .W(W), .DIV_INIT(DIV_INIT)) dut (
    .clk(clk), .rst(rst), .en(en), .div_wr(div_wr), .div_sel(div_sel),
    .div_val(div_val), .tick(tick), .clk_out(clk_out), .pend(pend)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 0; k < CH; k++) begin
      m_act[k]  = DIV_INIT;
      m_shd[k]  = DIV_INIT;
      m_left[k] = DIV_INIT;
      m_pend[k] = 1'b0;
      m_tick[k] = 1'b0;
      m_clk[k]  = 1'b0;
    end
  endfunction

  function automatic logic [OW-1:0] model_outputs();
    logic [OW-1:0] v;
    v = '0;
    for (int k = 0; k < CH; k++) begin
      v[k]        = m_tick[k];
      v[CH+k]     = m_clk[k];
      v[2*CH+k]   = m_pend[k];
    end
    return v;
  endfunction

  function automatic void model_step(bit e, bit wr, int sel, int val);
    bit prev_tick[CH];
    bit adv;
    bit nt;
    prev_tick = m_tick;
    for (int k = 0; k < CH; k++) begin
      adv = e;
`ifdef TICK_DIVIDER_CASCADE_EN
      if (k > 0) adv = e && prev_tick[k-1];
`endif
      nt = 1'b0;
      if (m_act[k] == 0) begin
        if (m_pend[k]) begin
          m_act[k]  = m_shd[k];
          m_left[k] = m_act[k];
          m_pend[k] = 1'b0;
        end
      end else if (adv) begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          nt = 1'b1;
          m_clk[k] = ~m_clk[k];
          if (m_pend[k]) begin
            m_act[k]  = m_shd[k];
            m_pend[k] = 1'b0;
          end
          m_left[k] = m_act[k];
        end
      end
      if (wr && sel == k) begin
        m_shd[k]  = val;
        m_pend[k] = 1'b1;
      end
      m_tick[k] = nt;
    end
  endfunction

  // driver tasks
  task automatic step(input bit e, input bit wr, input int sel, input int val);
    @(negedge clk);
    en      = e;
    div_wr  = wr;
    div_sel = SELW'(sel);
    div_val = W'(val);
    model_step(e, wr, sel, val);
    exp_q.push_back(model_outputs());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en     = 1'b0;
    div_wr = 1'b0;
    rst    = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({pend, clk_out, tick} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b expected=%b", {pend, clk_out, tick}, {OW{1'b0}});
    end
    @(negedge clk);
    checks++;
    if ({pend, clk_out, tick} !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%b expected=%b", {pend, clk_out, tick}, {OW{1'b0}});
    end
    rst = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [OW-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if ({pend, clk_out, tick} !== exp) begin
          errors++;
          $display("FAIL outputs t=%0t got pend=%b clk_out=%b tick=%b expected pend=%b clk_out=%b tick=%b",
                   $time, pend, clk_out, tick, exp[3*CH-1:2*CH], exp[2*CH-1:CH], exp[CH-1:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    int guard;
    model_reset();
    do_reset();

    // free run from reset, then a 3-cycle enable pause
    run(26);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0);
    run(10);

    // D=2 to channel 1 two cycles after its tick, plus an out-of-range write
    guard = 0;
    while (!m_tick[1] && guard < 40) begin run(1); guard++; end
    run(2);
    step(1'b1, 1'b1, 1, 2);
    step(1'b1, 1'b1, 3, 7);
    run(12);

    // disable channel 2, then D=1
    step(1'b1, 1'b1, 2, 0);
    run(20);
    step(1'b1, 1'b1, 2, 1);
    run(8);

    // D=6 on the exact terminal cycle of channel 0
    guard = 0;
    while (!(m_left[0] == 1 && !m_pend[0] && m_act[0] != 0) && guard < 40) begin
      run(1);
      guard++;
    end
    step(1'b1, 1'b1, 0, 6);
    run(20);

    // multiple writes before a terminal: last wins
    step(1'b1, 1'b1, 1, 5);
    step(1'b1, 1'b1, 1, 3);
    run(12);

    // randomized phase with a mid-run reset
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 300; i++) begin
        bit e;
        bit wr;
        e  = ($urandom_range(0, 9) != 0);
        wr = ($urandom_range(0, 7) == 0);
        step(e, wr, $urandom_range(0, 3), $urandom_range(0, 6));
      end
      do_reset();
      run(5);
    end
    run(70);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tick_divider.md
# tick_divider

Multi-channel, runtime-programmable tick and clock divider. It generates, from one system clock, CH independent single-cycle enable pulses (`tick`) and 50%-duty divided clocks (`clk_out`). Channels are optionally cascaded (seconds → minutes → hours) for the alarm-clock timebase. It replaces the fixed single-output divider for all new timekeeping, display-scan and debounce timebases.

## Interface
- `CH`, default 3: number of channels, at least 1.
- `W`, default 32: width of counter and divisor.
- `DIV_INIT`, default 50000000: reset divisor of every channel, range 0..2^W-1.
- `SELW` (localparam): `$clog2(CH)`, minimum 1.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `en`, input, 1: global count enable.
- `div_wr`, input, 1: divisor write strobe, one cycle per write.
- `div_sel`, input, SELW: target channel of the write.
- `div_val`, input, W: new divisor D.
- `tick`, output, CH: per-channel single-cycle pulse, registered.
- `clk_out`, output, CH: per-channel divided clock, registered.
- `pend`, output, CH: the channel has a written divisor not yet applied.

## Operation
- Per-channel state: `cnt[W]`, active divisor `act[W]`, shadow `shd[W]`, `pend`.
- Reset (async): `cnt`=0, `act`=`shd`=`DIV_INIT`, `pend`=0, `tick`=0, `clk_out`=0, all channels.
- Advance condition `adv[k]`: `en`, plus `tick[k-1]` for k>0 when cascade is compiled in.
- Counting when `act`≠0 and `adv`:
  - If `cnt`==`act`-1 (terminal), then `cnt`←0, `tick`←1, `clk_out`←~`clk_out`.
  - If `pend`, the terminal also applies the shadow: `act`←`shd`, `pend`←0.
  - Otherwise `cnt`←`cnt`+1.
- `tick`=0 in every cycle without a terminal. With `adv`=0 the counter holds, `tick`=0 and `clk_out` holds.
- D=0 disables the channel: `cnt` held 0, no ticks, `clk_out` frozen at its current level. A pending write to a disabled channel applies on the next edge regardless of `adv`: `act`←`shd`, `cnt`←0, `pend`←0.
- D=1: terminal on every advance. `tick` stays high while advancing and `clk_out` toggles every advance.
- Write: `div_wr` with `div_sel`<CH sets `shd[sel]`←`div_val` and `pend[sel]`←1. A write with `div_sel`≥CH is ignored.
- Multiple writes before a terminal: the last value wins.
- Write to a channel in the same cycle as its terminal: the terminal applies the *old* `shd` (only if `pend` was already set). The new value is captured and `pend` stays 1.
- Divisor changes never truncate a period in progress, so `clk_out` stays glitch-free.
- `rst` mid-count discards all counts, pending writes and output levels immediately.

## Timing
- Counting starts from `cnt`=0 with `en` held high and divisor D≥1. The first `tick` is high after the Dth rising edge. After that, `tick` has period D cycles and width 1. `clk_out` has period 2D cycles with 50% duty.
- `clk_out[k]` and `tick[k]` change on the same edge.
- Write-to-apply latency: at most the remaining count of the current period, plus 1 edge. A write to a disabled channel applies after 1 edge, and its first tick follows D edges after that.
- `pend` rises on the edge after `div_wr` and falls on the applying edge.
- Cascade: `tick[k]` lags the causing `tick[k-1]` by exactly one cycle.

## Configuration
- `TICK_DIVIDER_CASCADE_EN` defined: channel k>0 advances only on cycles where `tick[k-1]`=1 and `en`=1. Channel k's period is therefore the product of the divisors of channels 0..k, in clk cycles.
- Not defined: every channel advances on every `en` cycle, independently. There is no inter-channel logic.

## Test plan
All scenarios use CH=3, W=8, DIV_INIT=4.
- Reset release with `en`=1 → `tick[0..2]` high after edge 4, 8, 12…. `clk_out` toggles at those edges with period 8. During `rst`, all outputs are 0.
- `en` low for 3 cycles mid-count → all counts frozen, `tick`=0, `clk_out` holds. The next tick arrives 3 cycles later than without the pause.
- Write D=2 to channel 1, two cycles after a tick → `pend[1]`=1. The current 4-cycle period completes, then the ticks have period 2. `pend[1]` clears on the applying edge. An out-of-range write (`div_sel`=3) has no effect.
- Write D=0 to channel 2 → ticks stop after the current period and `clk_out[2]` freezes. Then write D=1 → applied after 1 edge, and `tick[2]` is high every cycle.
- Write D=6 on the exact terminal cycle of channel 0, with no prior pending write → the period stays 4 for one more period, then becomes 6. `pend[0]` stays 1 across the terminal edge.
- With `TICK_DIVIDER_CASCADE_EN`: `tick[1]` first appears 17 cycles after reset (16 plus 1 lag). `tick[2]` first appears at 66 cycles. Assert `rst` at cycle 30 → all outputs are 0 immediately, and counting restarts.
